// File: rtl/sdram_pkg.sv
// ============================================================================
// sdram_pkg : shared types and helpers for the SDRAM port multiplexer
// Revision  : 1.0
// ============================================================================
`default_nettype none

package sdram_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WDATA = 2'd2
    } arb_state_t;

    // Tag carries a port index; never narrower than one bit.
    function automatic int tag_width(input int num_ports);
        return (num_ports < 2) ? 1 : $clog2(num_ports);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sdram_tag_fifo.sv
// ============================================================================
// sdram_tag_fifo : first-word fall-through FIFO of outstanding read tags
// Revision       : 1.0
// ============================================================================
`default_nettype none

module sdram_tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wptr;
    logic [c_AW-1:0]  r_rptr;
    logic [c_AW:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == (c_AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign dout      = r_mem[r_rptr];
    assign w_do_pop  = pop & ~empty;
    // A pop frees the slot, so a simultaneous push is accepted even when full.
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + c_AW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + c_AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + (c_AW+1)'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - (c_AW+1)'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sdram_port_mux.sv
// ============================================================================
// sdram_port_mux : round-robin multiplexer of N requestor ports onto one
//                  SDRAM command / write / read-response interface
// Revision       : 1.0
// ============================================================================
`default_nettype none

module sdram_port_mux
    import sdram_pkg::*;
#(
    parameter int NUM_PORTS    = 4,
    parameter int ADDR_WIDTH   = 24,
    parameter int DATA_WIDTH   = 16,
    parameter int BURST_LENGTH = 8,
    parameter int TAG_DEPTH    = 8
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic [NUM_PORTS-1:0]             port_cmd_valid,
    output logic [NUM_PORTS-1:0]             port_cmd_ready,
    input  logic [NUM_PORTS-1:0]             port_cmd_we,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  port_cmd_addr,
    input  logic [NUM_PORTS-1:0]             port_wdata_valid,
    output logic [NUM_PORTS-1:0]             port_wdata_ready,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  port_wdata,
    output logic [NUM_PORTS-1:0]             port_resp_valid,
    input  logic [NUM_PORTS-1:0]             port_resp_ready,
    output logic                             port_resp_last,
    output logic [DATA_WIDTH-1:0]            port_resp_data,
    output logic                             cmd_valid,
    input  logic                             cmd_ready,
    output logic                             cmd_we,
    output logic [ADDR_WIDTH-1:0]            cmd_addr,
    output logic                             wdata_valid,
    input  logic                             wdata_ready,
    output logic [DATA_WIDTH-1:0]            wdata,
    input  logic                             resp_valid,
    output logic                             resp_ready,
    input  logic                             resp_last,
    input  logic [DATA_WIDTH-1:0]            resp_data,
    output logic                             err_orphan_resp
);

    localparam int c_TW = tag_width(NUM_PORTS);
    localparam int c_BW = $clog2(BURST_LENGTH) + 1;

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [c_TW-1:0]   r_last_grant;
    logic [c_TW-1:0]   r_grant;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic              r_we;
    logic [c_BW-1:0]   r_beat;
    logic              r_err;

    logic [NUM_PORTS-1:0]  w_elig;
    logic [c_TW-1:0]       w_sel;
    logic                  w_any;
    logic                  w_grant;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic                  w_sel_we;
    logic                  w_beat_hs;
    logic                  w_beat_last;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [c_TW-1:0]       w_head;

    assign w_elig = port_cmd_valid & (port_cmd_we | {NUM_PORTS{~w_full}});

    // Walk the rotation backwards so the last hit is the first port after last_grant.
    always_comb begin
        int v_idx;
        v_idx      = 0;
        w_any      = 1'b0;
        w_sel      = r_last_grant;
        w_sel_addr = '0;
        w_sel_we   = 1'b0;
        for (int i = NUM_PORTS; i >= 1; i--) begin
            v_idx = (int'(r_last_grant) + i) % NUM_PORTS;
            if (w_elig[v_idx]) begin
                w_any = 1'b1;
                w_sel = c_TW'(v_idx);
            end
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (c_TW'(p) == w_sel) begin
                w_sel_addr = port_cmd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_we   = port_cmd_we[p];
            end
        end
    end

    assign w_grant     = (r_state == ARB_IDLE) && w_any;
    assign w_beat_hs   = (r_state == ARB_WDATA) && wdata_valid && wdata_ready;
    assign w_beat_last = (r_beat == c_BW'(BURST_LENGTH - 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE:  if (w_any)     w_state_nxt = ARB_ISSUE;
            ARB_ISSUE: if (cmd_ready) w_state_nxt = r_we ? ARB_WDATA : ARB_IDLE;
            ARB_WDATA: if (w_beat_hs && w_beat_last) w_state_nxt = ARB_IDLE;
            default:   w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= ARB_IDLE;
            r_last_grant <= c_TW'(NUM_PORTS - 1);
            r_grant      <= '0;
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_beat       <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_grant      <= w_sel;
                r_last_grant <= w_sel;
                r_addr       <= w_sel_addr;
                r_we         <= w_sel_we;
            end
            if (w_beat_hs) begin
                r_beat <= w_beat_last ? '0 : r_beat + c_BW'(1);
            end
            if (resp_valid && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    assign cmd_valid       = (r_state == ARB_ISSUE);
    assign cmd_we          = r_we;
    assign cmd_addr        = r_addr;
    assign err_orphan_resp = r_err;
    assign port_resp_data  = resp_data;
    assign port_resp_last  = resp_last;

    // rstn gates the grant and drop paths so nothing handshakes while in reset.
    always_comb begin
        port_cmd_ready   = '0;
        port_wdata_ready = '0;
        port_resp_valid  = '0;
        wdata_valid      = 1'b0;
        wdata            = '0;
        resp_ready       = rstn && w_empty;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (rstn && w_grant && (c_TW'(p) == w_sel)) begin
                port_cmd_ready[p] = 1'b1;
            end
            if ((r_state == ARB_WDATA) && (c_TW'(p) == r_grant)) begin
                wdata_valid         = port_wdata_valid[p];
                wdata               = port_wdata[p*DATA_WIDTH +: DATA_WIDTH];
                port_wdata_ready[p] = wdata_ready;
            end
            if (!w_empty && (c_TW'(p) == w_head)) begin
                port_resp_valid[p] = resp_valid;
                resp_ready         = rstn && port_resp_ready[p];
            end
        end
    end

    assign w_push = (r_state == ARB_ISSUE) && cmd_ready && !r_we;
    assign w_pop  = resp_valid && resp_ready && resp_last && !w_empty;

    sdram_tag_fifo #(
        .WIDTH (c_TW),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (w_push),
        .pop   (w_pop),
        .din   (r_grant),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

endmodule

`default_nettype wire

// File: tb/tb_sdram_port_mux.sv
// ============================================================================
// tb_sdram_port_mux : directed, table-driven bench for sdram_port_mux
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_sdram_port_mux;

    localparam int NP = 4;
    localparam int AW = 24;
    localparam int DW = 16;
    localparam int BL = 8;
    localparam int TD = 8;

    logic              clk = 1'b0;
    logic              rstn;
    logic [NP-1:0]     port_cmd_valid;
    logic [NP-1:0]     port_cmd_ready;
    logic [NP-1:0]     port_cmd_we;
    logic [NP*AW-1:0]  port_cmd_addr;
    logic [NP-1:0]     port_wdata_valid;
    logic [NP-1:0]     port_wdata_ready;
    logic [NP*DW-1:0]  port_wdata;
    logic [NP-1:0]     port_resp_valid;
    logic [NP-1:0]     port_resp_ready;
    logic              port_resp_last;
    logic [DW-1:0]     port_resp_data;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_we;
    logic [AW-1:0]     cmd_addr;
    logic              wdata_valid;
    logic              wdata_ready;
    logic [DW-1:0]     wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic              resp_last;
    logic [DW-1:0]     resp_data;
    logic              err_orphan_resp;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [NP-1:0] vmask;
        logic [NP-1:0] wmask;
        logic [NP-1:0] exp_grant;
    } vec_t;

    vec_t tbl [6];

    always #5 clk = ~clk;

    sdram_port_mux #(
        .NUM_PORTS    (NP),
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .BURST_LENGTH (BL),
        .TAG_DEPTH    (TD)
    ) dut (
        .clk              (clk),
        .rstn             (rstn),
        .port_cmd_valid   (port_cmd_valid),
        .port_cmd_ready   (port_cmd_ready),
        .port_cmd_we      (port_cmd_we),
        .port_cmd_addr    (port_cmd_addr),
        .port_wdata_valid (port_wdata_valid),
        .port_wdata_ready (port_wdata_ready),
        .port_wdata       (port_wdata),
        .port_resp_valid  (port_resp_valid),
        .port_resp_ready  (port_resp_ready),
        .port_resp_last   (port_resp_last),
        .port_resp_data   (port_resp_data),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_we           (cmd_we),
        .cmd_addr         (cmd_addr),
        .wdata_valid      (wdata_valid),
        .wdata_ready      (wdata_ready),
        .wdata            (wdata),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_last        (resp_last),
        .resp_data        (resp_data),
        .err_orphan_resp  (err_orphan_resp)
    );

    function automatic logic [AW-1:0] tb_addr(input int p);
        return 24'h000100 ^ (AW'(p ^ 2) << 16);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Grant one command and complete its downstream command handshake.
    task automatic issue(input logic [NP-1:0] vm, input logic [NP-1:0] wm,
                         input logic [NP-1:0] eg, input string nm, output int gi);
        gi = 0;
        for (int i = 0; i < NP; i++) if (eg[i]) gi = i;
        port_cmd_valid = vm;
        port_cmd_we    = wm;
        cmd_ready      = 1'b0;
        settle();
        chk({nm, "_grant"}, 32'(port_cmd_ready), 32'(eg));
        chk({nm, "_cv_idle"}, 32'(cmd_valid), 0);
        step();
        port_cmd_valid[gi] = 1'b0;
        cmd_ready          = 1'b1;
        settle();
        chk({nm, "_cv"}, 32'(cmd_valid), 1);
        chk({nm, "_addr"}, 32'(cmd_addr), 32'(tb_addr(gi)));
        chk({nm, "_we"}, 32'(cmd_we), 32'(wm[gi]));
        chk({nm, "_rdy_issue"}, 32'(port_cmd_ready), 0);
        step();
        cmd_ready = 1'b0;
    endtask

    task automatic write_burst(input int gi, input logic [DW-1:0] base,
                               input bit toggle, input int nbeats, input string nm);
        int n;
        n = 0;
        for (int cyc = 0; cyc < 40 && n < nbeats; cyc++) begin
            port_wdata_valid[gi]        = 1'b1;
            port_wdata[gi*DW +: DW]     = base + DW'(n);
            wdata_ready                 = toggle ? cyc[0] : 1'b1;
            settle();
            chk({nm, "_wv"}, 32'(wdata_valid), 1);
            chk({nm, "_wd"}, 32'(wdata), 32'(base + DW'(n)));
            chk({nm, "_wrdy"}, 32'(port_wdata_ready), 32'(wdata_ready) << gi);
            chk({nm, "_excl"}, 32'(cmd_valid & wdata_valid), 0);
            step();
            if (wdata_ready) n++;
        end
        chk({nm, "_beats_done"}, 32'(n), 32'(nbeats));
        port_wdata_valid = '0;
        wdata_ready      = 1'b0;
    endtask

    task automatic drain_burst(input int p, input string nm);
        for (int b = 0; b < BL; b++) begin
            resp_valid      = 1'b1;
            resp_last       = (b == BL - 1);
            resp_data       = 16'hD000 + DW'(p << 8) + DW'(b);
            port_resp_ready = '1;
            if (b == 3) begin
                port_resp_ready[p] = 1'b0;
                settle();
                chk({nm, "_stall_rdy"}, 32'(resp_ready), 0);
                chk({nm, "_stall_rv"}, 32'(port_resp_valid), 32'(1) << p);
                step();
                port_resp_ready[p] = 1'b1;
            end
            settle();
            chk({nm, "_rv"}, 32'(port_resp_valid), 32'(1) << p);
            chk({nm, "_rrdy"}, 32'(resp_ready), 1);
            chk({nm, "_rdata"}, 32'(port_resp_data), 32'(resp_data));
            chk({nm, "_rlast"}, 32'(port_resp_last), 32'(b == BL - 1));
            step();
        end
        resp_valid = 1'b0;
        resp_last  = 1'b0;
    endtask

    initial begin
        int gi;
        tbl[0] = '{4'b1111, 4'b1111, 4'b1000};
        tbl[1] = '{4'b0110, 4'b0110, 4'b0010};
        tbl[2] = '{4'b0011, 4'b0000, 4'b0001};
        tbl[3] = '{4'b1001, 4'b1000, 4'b1000};
        tbl[4] = '{4'b0101, 4'b0100, 4'b0001};
        tbl[5] = '{4'b0101, 4'b0101, 4'b0100};

        for (int p = 0; p < NP; p++) port_cmd_addr[p*AW +: AW] = tb_addr(p);
        rstn             = 1'b0;
        port_cmd_valid   = '1;
        port_cmd_we      = '0;
        port_wdata_valid = '1;
        port_wdata       = '0;
        port_resp_ready  = '1;
        cmd_ready        = 1'b1;
        wdata_ready      = 1'b1;
        resp_valid       = 1'b1;
        resp_last        = 1'b1;
        resp_data        = '0;

        // Reset values, with busy inputs applied.
        step();
        step();
        chk("rst_cmd_ready", 32'(port_cmd_ready), 0);
        chk("rst_cmd_valid", 32'(cmd_valid), 0);
        chk("rst_cmd_addr", 32'(cmd_addr), 0);
        chk("rst_cmd_we", 32'(cmd_we), 0);
        chk("rst_wdata_valid", 32'(wdata_valid), 0);
        chk("rst_wdata_ready", 32'(port_wdata_ready), 0);
        chk("rst_resp_valid", 32'(port_resp_valid), 0);
        chk("rst_resp_ready", 32'(resp_ready), 0);
        chk("rst_err", 32'(err_orphan_resp), 0);
        port_cmd_valid   = '0;
        port_wdata_valid = '0;
        cmd_ready        = 1'b0;
        wdata_ready      = 1'b0;
        resp_valid       = 1'b0;
        resp_last        = 1'b0;
        rstn             = 1'b1;
        step();

        // Four simultaneous reads: round robin from port 0.
        for (int k = 0; k < NP; k++) begin
            issue(4'hF & ~((4'h1 << k) - 4'h1), 4'h0, 4'h1 << k, "rr4", gi);
        end
        for (int k = 0; k < NP; k++) drain_burst(k, "rr4_resp");
        chk("rr4_err", 32'(err_orphan_resp), 0);

        // Port 2 write with toggling wdata_ready and one held-off cmd cycle.
        port_cmd_valid = 4'b0100;
        port_cmd_we    = 4'b0100;
        settle();
        chk("wr2_grant", 32'(port_cmd_ready), 32'(4'b0100));
        step();
        port_cmd_valid = '0;
        settle();
        chk("wr2_cv_hold", 32'(cmd_valid), 1);
        step();
        chk("wr2_cv_held", 32'(cmd_valid), 1);
        chk("wr2_addr", 32'(cmd_addr), 32'h000100);
        chk("wr2_we", 32'(cmd_we), 1);
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        settle();
        chk("wr2_cv_done", 32'(cmd_valid), 0);
        write_burst(2, 16'h00A0, 1'b1, BL, "wr2");

        // Table of arbitration vectors; writes get a full burst.
        for (int k = 0; k < 6; k++) begin
            issue(tbl[k].vmask, tbl[k].wmask, tbl[k].exp_grant, $sformatf("tbl%0d", k), gi);
            port_cmd_valid = '0;
            if (tbl[k].wmask[gi]) write_burst(gi, DW'(16'h1000 * (k + 1)), 1'b0, BL, $sformatf("tbl%0d", k));
        end
        drain_burst(0, "tbl_resp_a");
        drain_burst(0, "tbl_resp_b");

        // Port 1 then port 3 reads: responses routed in issue order.
        issue(4'b0010, 4'b0000, 4'b0010, "rd1", gi);
        issue(4'b1000, 4'b0000, 4'b1000, "rd3", gi);
        drain_burst(1, "rd1_resp");
        drain_burst(3, "rd3_resp");

        // Fill the tag FIFO; a pending read must not block a write elsewhere.
        for (int k = 0; k < TD; k++) issue(4'h1 << (k % NP), 4'h0, 4'h1 << (k % NP), "fill", gi);
        issue(4'b0011, 4'b0010, 4'b0010, "full_wr1", gi);
        write_burst(1, 16'h7700, 1'b0, BL, "full_wr1");
        settle();
        chk("full_rd0_held", 32'(port_cmd_ready), 0);
        drain_burst(0, "full_pop");
        settle();
        chk("full_rd0_free", 32'(port_cmd_ready), 32'(4'b0001));
        issue(4'b0001, 4'b0000, 4'b0001, "full_rd0", gi);
        for (int k = 1; k <= TD; k++) drain_burst(k % NP, "full_drain");

        // Orphan response: dropped and latched until reset.
        resp_valid = 1'b1;
        resp_last  = 1'b1;
        port_resp_ready = '0;
        settle();
        chk("orph_rrdy", 32'(resp_ready), 1);
        chk("orph_rv", 32'(port_resp_valid), 0);
        step();
        resp_valid = 1'b0;
        resp_last  = 1'b0;
        step();
        step();
        chk("orph_err_sticky", 32'(err_orphan_resp), 1);
        rstn = 1'b0;
        settle();
        chk("orph_err_clr", 32'(err_orphan_resp), 0);
        step();
        rstn = 1'b1;
        step();
        chk("orph_err_after", 32'(err_orphan_resp), 0);

        // Reset in the middle of a write burst.
        issue(4'b0001, 4'b0001, 4'b0001, "mid_wr0", gi);
        port_cmd_valid = '0;
        write_burst(0, 16'h3300, 1'b0, 4, "mid_wr0");
        port_wdata_valid = 4'b0001;
        wdata_ready      = 1'b1;
        settle();
        chk("mid_wv_before", 32'(wdata_valid), 1);
        rstn = 1'b0;
        settle();
        chk("mid_rst_wv", 32'(wdata_valid), 0);
        chk("mid_rst_wrdy", 32'(port_wdata_ready), 0);
        chk("mid_rst_cv", 32'(cmd_valid), 0);
        chk("mid_rst_addr", 32'(cmd_addr), 0);
        chk("mid_rst_we", 32'(cmd_we), 0);
        step();
        port_wdata_valid = '0;
        wdata_ready      = 1'b0;
        rstn             = 1'b1;
        step();
        issue(4'b0001, 4'b0000, 4'b0001, "post_rst_rd0", gi);
        port_cmd_valid = '0;
        drain_burst(0, "post_rst_resp");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
